control_vga_param: RTL and testbench
====================================

# control_vga_param

Parametrised single-clock VGA controller that supersedes the fixed 640x480 chain of divider, counters, sync generators, chroma control and output stage. It derives a pixel enable from the system clock and generates H/V timing from parameters. It presents the pixel coordinate to the character memory, takes back the one-bit `letra` sample, and drives RGB and sync outputs aligned to that sample. Letter and background colours are edited per channel with debounced-upstream push buttons.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (≥1); 50 MHz / 2 = 25 MHz pixel rate.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48 (pixels).
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33 (lines).
- `SYNC_POL`, 0: asserted level of `Hsinc`/`Vsinc`.
- `R_W`, `G_W`, `B_W`: 3, 3, 2 (colour channel widths).
- `CW`, 10: coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1.
- Clocking: one clock; reset is synchronous and active-low.
- `Clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `Up`, `Down`, `TC`  in  1 each  buttons, asynchronous to `Clock`.
- `Lp`  in  1  level select for editing: 1 = letter colour, 0 = background colour.
- `letra`  in  1  memory pixel for the `PosX`/`PosY` presented one pixel earlier.
- `PosX`, `PosY`  out  CW each  current counter coordinate.
- `pix_en`  out  1  one-`Clock` pixel strobe.
- `frame_start`  out  1  pulses on the `pix_en` where the counters become (0,0).
- `Rojo`  out  R_W;  `Verde`  out  G_W;  `Azul`  out  B_W.
- `Hsinc`, `Vsinc`  out  1 each.

## Operation
- Divider: `div` counts 0..CLK_DIV-1. `pix_en` = (`div` == CLK_DIV-1). With CLK_DIV=1, `pix_en` is constantly 1.
- Timing constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- H counter: advances on `pix_en` and wraps H_TOTAL-1→0.
- V counter: advances only when H wraps; wraps V_TOTAL-1→0 on the same `pix_en`. Counters drive `PosX`/`PosY` directly.
- Stage-0 decode:
  - `act` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - `hs` = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - `vs` = v in the analogous range.
- Stage-1 (output registers, loaded on `pix_en`):
  - `Hsinc`/`Vsinc` = (`hs`/`vs` delayed one pixel) ? SYNC_POL : !SYNC_POL.
  - When delayed `act` = 0: RGB = 0.
  - Otherwise RGB = `letra` ? ColorL : ColorP.
- Buttons: 2-FF synchroniser plus rising-edge detect in the `Clock` domain, independent of `pix_en`.
- `TC` edge cycles the selected channel R→G→B→R.
- `Up` edge: the selected channel of the register chosen by `Lp` increments, saturating at 2^W-1.
- `Down` edge: the same channel decrements, saturating at 0.
- `Up` and `Down` edges in the same cycle: no change.
- `TC` edge together with `Up`/`Down`: the adjustment uses the old channel; the channel select then advances.
- Colour edits take effect at the next `pix_en` load; no frame-boundary deferral.

## Timing
- Reset values, one edge after `reset`=0 is sampled:
  - `div`, h, v, `PosX`, `PosY` = 0.
  - `pix_en` = 0 if CLK_DIV>1, else 1.
  - `frame_start` = 0.
  - `Hsinc` = `Vsinc` = !SYNC_POL.
  - RGB = 0.
  - ColorL = all ones; ColorP = 0; channel = R; synchronisers cleared.
- Reset mid-frame: the frame is abandoned and restarts at (0,0) after release. No partial sync pulse persists.
- `letra` contract: sampled on the `pix_en` after its coordinate was presented, i.e. one pixel of memory latency.
- Outputs lag `PosX`/`PosY` by exactly 1 pixel. Syncs and colour stay mutually aligned.
- `frame_start` is high for one `Clock` cycle, coincident with the `pix_en` that loads (0,0).
- Button to colour register: 3 `Clock` cycles (2 sync + edge). Colour register to pins: by the next `pix_en`.

## Structure
- Package `vga_pkg` holds:
  - default timing constants;
  - the channel select enum (R, G, B);
  - the H_TOTAL/V_TOTAL derivation functions.
- Sub-module `detector_flanco` (synchroniser + rising-edge pulse) is instantiated three times (`Up`, `Down`, `TC`).
- Timing, colour registers and output stage stay in the top module.

## Test plan
- Reset/defaults: hold `reset`=0 for 4 clocks with `Up`/`Down`/`TC` toggling. Required: all outputs at reset values, `Hsinc`=`Vsinc`=1 (SYNC_POL=0), colours unchanged.
- Line/frame timing, defaults:
  - `Hsinc` low for 192 clocks, period 1600 clocks;
  - `Vsinc` low for 2 lines (3200 clocks), period 525 lines;
  - `frame_start` every 840000 clocks.
- Parametric: CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, SYNC_POL=1. Required: `Hsinc` high for pixels 10–11 (output lags by one), H_TOTAL=14, V_TOTAL=7.
- Colour edit, `Lp`=1:
  - channel R at 7, `Up` → stays 7;
  - `Down` ×3 → 4;
  - `TC` then `Down` → G goes 7→6;
  - simultaneous `Up`+`Down` → unchanged.
- Pixel path: memory model returns `letra` = `PosX`[3], latency 1. Required: at pixel 8 output = ColorL, at pixel 7 = ColorP, at h ≥ 640 output = 0.
- Reset pulse at line 200, h=300: next frame starts at (0,0), `frame_start` follows 840000 clocks after release, and `Hsinc`/`Vsinc` show no runt pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, channel select type and small helpers for the
// parametrised VGA controller.
package vga_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } canal_t;

    function automatic int h_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

    function automatic canal_t next_canal(input canal_t c);
        case (c)
            CH_R:    return CH_G;
            CH_G:    return CH_B;
            default: return CH_R;
        endcase
    endfunction

    // Colour channels are at most 8 bits wide; callers widen/narrow around this.
    function automatic logic [7:0] sat_step(input logic [7:0] val, input logic [7:0] top,
                                            input logic up);
        if (up)
            return (val == top) ? val : val + 8'd1;
        return (val == 8'd0) ? val : val - 8'd1;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop synchroniser for an asynchronous button followed by a
// single-cycle rising-edge pulse in the clk_sys domain.
module detector_flanco (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic boton,
    output logic pulso
);

    logic [2:0] sh;

    always_ff @(posedge clk_sys) begin
        if (!rst_b)
            sh <= '0;
        else
            sh <= {sh[1:0], boton};
    end

    assign pulso = sh[1] & ~sh[2];

endmodule

// File: rtl/control_vga_param.sv
// Parametrised VGA controller: pixel divider, H/V counters, sync decode,
// button-edited letter/background colours and a one-pixel output stage.
module control_vga_param
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int CW       = 10
) (
    input  logic           Clock,
    input  logic           reset,
    input  logic           Up,
    input  logic           Down,
    input  logic           TC,
    input  logic           Lp,
    input  logic           letra,
    output logic [CW-1:0]  PosX,
    output logic [CW-1:0]  PosY,
    output logic           pix_en,
    output logic           frame_start,
    output logic [R_W-1:0] Rojo,
    output logic [G_W-1:0] Verde,
    output logic [B_W-1:0] Azul,
    output logic           Hsinc,
    output logic           Vsinc
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [7:0]    R_TOP    = 8'((1 << R_W) - 1);
    localparam logic [7:0]    G_TOP    = 8'((1 << G_W) - 1);
    localparam logic [7:0]    B_TOP    = 8'((1 << B_W) - 1);

    logic [DW-1:0]  div;
    logic [CW-1:0]  h, v;
    logic           h_last, v_last;
    logic           act, hs, vs;
    logic           up_p, dn_p, tc_p;
    logic           inc, dec;
    canal_t         canal;
    logic [R_W-1:0] l_r, p_r;
    logic [G_W-1:0] l_g, p_g;
    logic [B_W-1:0] l_b, p_b;

    // With CLK_DIV == 1 div never leaves 0, so pix_en stays high.
    always_ff @(posedge Clock) begin
        if (!reset || pix_en)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign pix_en = (div == DIV_LAST);
    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);

    always_ff @(posedge Clock) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last)
                v <= v_last ? '0 : v + 1'b1;
        end
    end

    assign PosX        = h;
    assign PosY        = v;
    assign frame_start = pix_en & h_last & v_last;

    assign act = (h < H_ACT) && (v < V_ACT);
    assign hs  = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vs  = (v >= VS_FIRST) && (v <= VS_LAST);

    detector_flanco u_up (.clk_sys(Clock), .rst_b(reset), .boton(Up),   .pulso(up_p));
    detector_flanco u_dn (.clk_sys(Clock), .rst_b(reset), .boton(Down), .pulso(dn_p));
    detector_flanco u_tc (.clk_sys(Clock), .rst_b(reset), .boton(TC),   .pulso(tc_p));

    assign inc = up_p & ~dn_p;
    assign dec = dn_p & ~up_p;

    // The adjustment uses the channel held before a simultaneous TC advances it.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            l_r   <= '1;
            l_g   <= '1;
            l_b   <= '1;
            p_r   <= '0;
            p_g   <= '0;
            p_b   <= '0;
            canal <= CH_R;
        end else begin
            if (inc || dec) begin
                unique case (canal)
                    CH_R: if (Lp) l_r <= R_W'(sat_step(8'(l_r), R_TOP, inc));
                          else    p_r <= R_W'(sat_step(8'(p_r), R_TOP, inc));
                    CH_G: if (Lp) l_g <= G_W'(sat_step(8'(l_g), G_TOP, inc));
                          else    p_g <= G_W'(sat_step(8'(p_g), G_TOP, inc));
                    CH_B: if (Lp) l_b <= B_W'(sat_step(8'(l_b), B_TOP, inc));
                          else    p_b <= B_W'(sat_step(8'(p_b), B_TOP, inc));
                    default: ;
                endcase
            end
            if (tc_p)
                canal <= next_canal(canal);
        end
    end

    // letra belongs to the coordinate being left on this pix_en, so sync and
    // colour are registered together and appear one pixel behind PosX/PosY.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            Hsinc <= ~SYNC_POL;
            Vsinc <= ~SYNC_POL;
            Rojo  <= '0;
            Verde <= '0;
            Azul  <= '0;
        end else if (pix_en) begin
            Hsinc <= hs ? SYNC_POL : ~SYNC_POL;
            Vsinc <= vs ? SYNC_POL : ~SYNC_POL;
            if (!act) begin
                Rojo  <= '0;
                Verde <= '0;
                Azul  <= '0;
            end else if (letra) begin
                Rojo  <= l_r;
                Verde <= l_g;
                Azul  <= l_b;
            end else begin
                Rojo  <= p_r;
                Verde <= p_g;
                Azul  <= p_b;
            end
        end
    end

endmodule

// File: tb/tb_control_vga_param.sv
// Bench for control_vga_param: three parameter sets share the buttons and are
// compared every clock against a frame-arithmetic reference model.
module tb_control_vga_param;

    // instance 0 = small CLK_DIV=2, 1 = tiny CLK_DIV=1 SYNC_POL=1, 2 = defaults
    localparam int P_CD [3] = '{2, 1, 2};
    localparam int P_HA [3] = '{16, 8, 640};
    localparam int P_HF [3] = '{2, 2, 16};
    localparam int P_HS [3] = '{4, 2, 96};
    localparam int P_HB [3] = '{2, 2, 48};
    localparam int P_VA [3] = '{6, 4, 480};
    localparam int P_VF [3] = '{1, 1, 10};
    localparam int P_VS [3] = '{2, 1, 2};
    localparam int P_VB [3] = '{1, 1, 33};
    localparam int P_POL[3] = '{0, 1, 0};
    localparam int CMAX [3] = '{7, 7, 3};

    logic Clock = 1'b0;
    logic reset = 1'b0;
    logic Up = 1'b0, Down = 1'b0, TC = 1'b0, Lp = 1'b1;
    logic letra_v [3];

    logic [9:0] posx_a, posy_a, posx_b, posy_b, posx_c, posy_c;
    logic       pe_a, pe_b, pe_c, fs_a, fs_b, fs_c;
    logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
    logic [2:0] r_a, r_b, r_c, g_a, g_b, g_c;
    logic [1:0] b_a, b_b, b_c;
    logic [31:0] obs [3];

    always #5 Clock = ~Clock;

    initial for (int i = 0; i < 3; i++) letra_v[i] = 1'b0;

    control_vga_param #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) dut_a (
        .Clock(Clock), .reset(reset), .Up(Up), .Down(Down), .TC(TC), .Lp(Lp),
        .letra(letra_v[0]), .PosX(posx_a), .PosY(posy_a), .pix_en(pe_a),
        .frame_start(fs_a), .Rojo(r_a), .Verde(g_a), .Azul(b_a), .Hsinc(hs_a), .Vsinc(vs_a));

    control_vga_param #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut_b (
        .Clock(Clock), .reset(reset), .Up(Up), .Down(Down), .TC(TC), .Lp(Lp),
        .letra(letra_v[1]), .PosX(posx_b), .PosY(posy_b), .pix_en(pe_b),
        .frame_start(fs_b), .Rojo(r_b), .Verde(g_b), .Azul(b_b), .Hsinc(hs_b), .Vsinc(vs_b));

    control_vga_param dut_c (
        .Clock(Clock), .reset(reset), .Up(Up), .Down(Down), .TC(TC), .Lp(Lp),
        .letra(letra_v[2]), .PosX(posx_c), .PosY(posy_c), .pix_en(pe_c),
        .frame_start(fs_c), .Rojo(r_c), .Verde(g_c), .Azul(b_c), .Hsinc(hs_c), .Vsinc(vs_c));

    assign obs[0] = {posx_a, posy_a, pe_a, fs_a, hs_a, vs_a, r_a, g_a, b_a};
    assign obs[1] = {posx_b, posy_b, pe_b, fs_b, hs_b, vs_b, r_b, g_b, b_b};
    assign obs[2] = {posx_c, posy_c, pe_c, fs_c, hs_c, vs_c, r_c, g_c, b_c};

    int checks = 0;
    int errors = 0;
    int letra_mode = 0;   // 0 memory (PosX[3]), 1 random, 2 const 1, 3 const 0

    // reference model state
    int cyc [3], q [3];
    int e_hs [3], e_vs [3], e_r [3], e_g [3], e_b [3];
    bit last_act [3];
    int cl [3], cp [3], sel;
    bit hu [3], hd [3], ht [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int ht_of(input int i);
        return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
    endfunction

    function automatic int vt_of(input int i);
        return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        int x, y;
        bit pe, fs;
        x  = q[i] % ht_of(i);
        y  = (q[i] / ht_of(i)) % vt_of(i);
        pe = (cyc[i] % P_CD[i]) == P_CD[i] - 1;
        fs = pe && x == ht_of(i) - 1 && y == vt_of(i) - 1;
        return {10'(x), 10'(y), pe, fs, 1'(e_hs[i]), 1'(e_vs[i]),
                3'(e_r[i]), 3'(e_g[i]), 2'(e_b[i])};
    endfunction

    task automatic model_step();
        int x, y;
        bit act, ue, de, te;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                cyc[i] = 0; q[i] = 0; last_act[i] = 0;
                e_hs[i] = 1 - P_POL[i]; e_vs[i] = 1 - P_POL[i];
                e_r[i] = 0; e_g[i] = 0; e_b[i] = 0;
                cl[i] = CMAX[i]; cp[i] = 0;
                hu[i] = 0; hd[i] = 0; ht[i] = 0;
            end
            sel = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (cyc[i] % P_CD[i] == P_CD[i] - 1) begin
                x   = q[i] % ht_of(i);
                y   = (q[i] / ht_of(i)) % vt_of(i);
                act = x < P_HA[i] && y < P_VA[i];
                e_hs[i] = (x >= P_HA[i] + P_HF[i] && x < P_HA[i] + P_HF[i] + P_HS[i])
                          ? P_POL[i] : 1 - P_POL[i];
                e_vs[i] = (y >= P_VA[i] + P_VF[i] && y < P_VA[i] + P_VF[i] + P_VS[i])
                          ? P_POL[i] : 1 - P_POL[i];
                e_r[i] = !act ? 0 : letra_v[i] ? cl[0] : cp[0];
                e_g[i] = !act ? 0 : letra_v[i] ? cl[1] : cp[1];
                e_b[i] = !act ? 0 : letra_v[i] ? cl[2] : cp[2];
                last_act[i] = act;
                q[i]++;
            end
            cyc[i]++;
        end
        // a button level seen at edge n-2 but not n-3 acts at edge n
        ue = hu[1] && !hu[2];
        de = hd[1] && !hd[2];
        te = ht[1] && !ht[2];
        if (ue != de) begin
            if (Lp) cl[sel] = ue ? (cl[sel] < CMAX[sel] ? cl[sel] + 1 : cl[sel])
                                 : (cl[sel] > 0 ? cl[sel] - 1 : 0);
            else    cp[sel] = ue ? (cp[sel] < CMAX[sel] ? cp[sel] + 1 : cp[sel])
                                 : (cp[sel] > 0 ? cp[sel] - 1 : 0);
        end
        if (te) sel = (sel + 1) % 3;
        hu[2] = hu[1]; hu[1] = hu[0]; hu[0] = Up;
        hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = Down;
        ht[2] = ht[1]; ht[1] = ht[0]; ht[0] = TC;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        model_step();
        for (int i = 0; i < 3; i++) check($sformatf("stream%0d", i), obs[i], exp_vec(i));
        for (int i = 0; i < 3; i++) begin
            case (letra_mode)
                0:       letra_v[i] = obs[i][25];
                1:       letra_v[i] = 1'($urandom_range(0, 1));
                2:       letra_v[i] = 1'b1;
                default: letra_v[i] = 1'b0;
            endcase
        end
    endtask

    function automatic bit asserted(input int i, input int which);
        case (which)
            0:       return obs[i][9] == 1'(P_POL[i]);
            1:       return obs[i][8] == 1'(P_POL[i]);
            default: return obs[i][10];
        endcase
    endfunction

    task automatic measure(input int i, input int which, input int exp_w, input int exp_p,
                           input string name, output int x0);
        int bud, t, w, p;
        bud = 3 * exp_p + 20;
        t = 0;
        x0 = -1;
        while (asserted(i, which) && t < bud) begin tick(); t++; end
        while (!asserted(i, which) && t < bud) begin tick(); t++; end
        x0 = int'(obs[i][31:22]);
        w = 0;
        while (asserted(i, which) && t < bud) begin tick(); t++; w++; end
        p = w;
        while (!asserted(i, which) && t < bud) begin tick(); t++; p++; end
        if (t >= bud) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d clocks", name, t);
        end else begin
            check({name, "_width"}, w, exp_w);
            check({name, "_period"}, p, exp_p);
        end
    endtask

    task automatic wait_pos(input int i, input int x, input int y, input string name);
        int t;
        t = 0;
        while (!(obs[i][31:22] == 10'(x) && obs[i][21:12] == 10'(y)) && t < 2000) begin
            tick(); t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s wait for (%0d,%0d) timed out", name, x, y);
        end
    endtask

    typedef struct {
        bit up, dn, tc, lp;
        logic [7:0] exp_l;   // {R,G,B} letter colour after the press
        logic [7:0] exp_p;   // {R,G,B} background colour after the press
    } edit_t;

    edit_t tbl [14];

    task automatic show_colour(input logic [7:0] want, input bit lv, input string name);
        int t;
        letra_mode = lv ? 2 : 3;
        tick(); tick();
        t = 0;
        while (!last_act[1] && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s no active pixel within %0d clocks", name, t);
        end else begin
            check(name, {24'd0, r_b, g_b, b_b}, {24'd0, want});
        end
    endtask

    initial begin
        int x0, t;

        tbl[0]  = '{1, 0, 0, 1, {3'd7, 3'd7, 2'd3}, 8'h00};
        tbl[1]  = '{0, 1, 0, 1, {3'd6, 3'd7, 2'd3}, 8'h00};
        tbl[2]  = '{0, 1, 0, 1, {3'd5, 3'd7, 2'd3}, 8'h00};
        tbl[3]  = '{0, 1, 0, 1, {3'd4, 3'd7, 2'd3}, 8'h00};
        tbl[4]  = '{0, 0, 1, 1, {3'd4, 3'd7, 2'd3}, 8'h00};
        tbl[5]  = '{0, 1, 0, 1, {3'd4, 3'd6, 2'd3}, 8'h00};
        tbl[6]  = '{1, 1, 0, 1, {3'd4, 3'd6, 2'd3}, 8'h00};
        tbl[7]  = '{1, 0, 1, 1, {3'd4, 3'd7, 2'd3}, 8'h00};
        tbl[8]  = '{0, 1, 0, 1, {3'd4, 3'd7, 2'd2}, 8'h00};
        tbl[9]  = '{0, 0, 1, 1, {3'd4, 3'd7, 2'd2}, 8'h00};
        tbl[10] = '{1, 0, 0, 0, {3'd4, 3'd7, 2'd2}, {3'd1, 3'd0, 2'd0}};
        tbl[11] = '{0, 0, 1, 0, {3'd4, 3'd7, 2'd2}, {3'd1, 3'd0, 2'd0}};
        tbl[12] = '{0, 1, 0, 0, {3'd4, 3'd7, 2'd2}, {3'd1, 3'd0, 2'd0}};
        tbl[13] = '{1, 0, 0, 0, {3'd4, 3'd7, 2'd2}, {3'd1, 3'd1, 2'd0}};

        // reset held with buttons toggling
        for (int k = 0; k < 4; k++) begin
            tick();
            Up = ~Up; Down = ~Down; TC = ~TC;
        end
        check("rst_hs_c", hs_c, 1'b1);
        check("rst_vs_c", vs_c, 1'b1);
        check("rst_hs_b", hs_b, 1'b0);
        check("rst_rgb_c", {r_c, g_c, b_c}, 8'h00);
        check("rst_pos_c", {posx_c, posy_c}, 20'd0);
        check("rst_pe_c", pe_c, 1'b0);
        check("rst_pe_b", pe_b, 1'b1);
        check("rst_fs_a", fs_a, 1'b0);
        Up = 0; Down = 0; TC = 0;
        tick(); tick();
        reset = 1'b1;

        // line / frame timing
        measure(2, 0, 192, 1600, "c_hsync", x0);
        measure(0, 0, 8, 48, "a_hsync", x0);
        measure(0, 1, 96, 480, "a_vsync", x0);
        measure(0, 2, 1, 480, "a_frame", x0);
        measure(1, 0, 2, 14, "b_hsync", x0);
        check("b_hsync_first_posx", x0, 11);
        measure(1, 1, 14, 98, "b_vsync", x0);
        measure(1, 2, 1, 98, "b_frame", x0);

        // colour edits observed on instance 1
        for (int k = 0; k < 14; k++) begin
            Lp = tbl[k].lp;
            Up = tbl[k].up; Down = tbl[k].dn; TC = tbl[k].tc;
            tick(); tick();
            Up = 0; Down = 0; TC = 0;
            for (int j = 0; j < 4; j++) tick();
            show_colour(tbl[k].exp_l, 1'b1, $sformatf("edit%0d_letter", k));
            show_colour(tbl[k].exp_p, 1'b0, $sformatf("edit%0d_back", k));
        end

        // pixel path with letra = PosX[3]
        letra_mode = 0;
        wait_pos(0, 8, 1, "pix7");
        check("pix7_back", {r_a, g_a, b_a}, {3'd1, 3'd1, 2'd0});
        wait_pos(0, 9, 1, "pix8");
        check("pix8_letter", {r_a, g_a, b_a}, {3'd4, 3'd7, 2'd2});
        wait_pos(0, 17, 1, "pix16");
        check("pix16_blank", {r_a, g_a, b_a}, 8'h00);

        // reset mid-frame
        wait_pos(0, 10, 3, "midreset");
        reset = 1'b0;
        tick(); tick(); tick();
        check("midrst_hs_a", hs_a, 1'b1);
        check("midrst_vs_a", vs_a, 1'b1);
        reset = 1'b1;
        t = 0;
        while (t < 1000) begin
            tick(); t++;
            if (fs_a) break;
        end
        check("midrst_frame_start_a", t, 479);

        // randomized traffic against the model
        letra_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if ($urandom_range(0, 5) == 0) Up = ~Up;
            if ($urandom_range(0, 5) == 0) Down = ~Down;
            if ($urandom_range(0, 7) == 0) TC = ~TC;
            if ($urandom_range(0, 15) == 0) Lp = ~Lp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
